// File: rtl/voter_pkg.sv
// Shared types and width helpers for the threshold voter and its popcount tree.
package voter_pkg;

  typedef enum logic [1:0] {
    MODE_ALL = 2'd0,
    MODE_MAJ = 2'd1,
    MODE_ANY = 2'd2,
    MODE_THR = 2'd3
  } mode_e;

  // Filter run counter; wide enough for HOLD up to 255.
  localparam int unsigned HoldCntW = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/threshold_voter_if.sv
// Sample/result bus of the threshold voter. ch_en exists only with VOTER_CHMASK_EN.
interface threshold_voter_if
  import voter_pkg::*;
#(
  parameter int unsigned N = 3
);

  localparam int unsigned CW = cnt_width(N);

  logic          in_vld;
  logic [N-1:0]  in_bits;
  logic [1:0]    mode;
`ifdef VOTER_CHMASK_EN
  logic [N-1:0]  ch_en;
`endif
  logic          out_vld;
  logic [CW-1:0] count;
  logic          raw;
  logic          vote;
  logic          vote_chg;

  modport master (
`ifdef VOTER_CHMASK_EN
    output ch_en,
`endif
    output in_vld,
    output in_bits,
    output mode,
    input  out_vld,
    input  count,
    input  raw,
    input  vote,
    input  vote_chg
  );

  modport slave (
`ifdef VOTER_CHMASK_EN
    input  ch_en,
`endif
    input  in_vld,
    input  in_bits,
    input  mode,
    output out_vld,
    output count,
    output raw,
    output vote,
    output vote_chg
  );

endinterface

// File: rtl/popcount_n.sv
// Combinational popcount of N bits as a balanced recursive adder tree.
module popcount_n
  import voter_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned CW = cnt_width(N)
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);

  if (N == 1) begin : g_leaf
    assign cnt_o = bits_i;
  end else begin : g_split
    localparam int unsigned NLo  = N / 2;
    localparam int unsigned NHi  = N - NLo;
    localparam int unsigned CwLo = cnt_width(NLo);
    localparam int unsigned CwHi = cnt_width(NHi);

    logic [CwLo-1:0] cnt_lo;
    logic [CwHi-1:0] cnt_hi;

    popcount_n #(.N(NLo)) u_lo (
      .bits_i (bits_i[NLo-1:0]),
      .cnt_o  (cnt_lo)
    );

    popcount_n #(.N(NHi)) u_hi (
      .bits_i (bits_i[N-1:NLo]),
      .cnt_o  (cnt_hi)
    );

    // Sum of two halves never exceeds N, so CW bits always suffice.
    assign cnt_o = CW'(cnt_lo) + CW'(cnt_hi);
  end

endmodule

// File: rtl/threshold_voter.sv
// Registered N-channel voter: popcount + rule (stage 1), output regs + persistence filter
// (stage 2). Optional channel masking is enabled by defining VOTER_CHMASK_EN.
module threshold_voter
  import voter_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned THRESH = 2,
  parameter int unsigned HOLD   = 1,
  localparam int unsigned CW    = cnt_width(N)
) (
  input logic            clk,
  input logic            rst_n,
  threshold_voter_if.slave bus
);

  localparam logic [CW-1:0]       ThrC     = CW'(THRESH);
  localparam logic [HoldCntW-1:0] HoldLast = HoldCntW'(HOLD - 1);

  logic [N-1:0]  bits_m;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n_en;
  logic [CW:0]   cnt_x2;
  mode_e         mode_sel;
  logic          raw_c;

  logic                s1_vld_q, s1_vld_d;
  logic [CW-1:0]       s1_cnt_q, s1_cnt_d;
  logic                s1_raw_q, s1_raw_d;
  logic                out_vld_q, out_vld_d;
  logic [CW-1:0]       count_q, count_d;
  logic                raw_q, raw_d;
  logic                vote_q, vote_d;
  logic                vote_chg_q, vote_chg_d;
  logic [HoldCntW-1:0] hold_cnt_q, hold_cnt_d;

`ifdef VOTER_CHMASK_EN
  assign bits_m = bus.in_bits & bus.ch_en;

  popcount_n #(.N(N)) u_pop_en (
    .bits_i (bus.ch_en),
    .cnt_o  (n_en)
  );
`else
  assign bits_m = bus.in_bits;
  assign n_en   = CW'(N);
`endif

  popcount_n #(.N(N)) u_pop_bits (
    .bits_i (bits_m),
    .cnt_o  (cnt)
  );

  assign mode_sel = mode_e'(bus.mode);
  assign cnt_x2   = {cnt, 1'b0};

  always_comb begin
    raw_c = 1'b0;
    case (mode_sel)
      MODE_ALL: raw_c = (n_en != '0) && (cnt == n_en);
      // Strict greater-than makes an even-N tie a 0.
      MODE_MAJ: raw_c = cnt_x2 > {1'b0, n_en};
      MODE_ANY: raw_c = cnt != '0;
      MODE_THR: raw_c = cnt >= ThrC;
      default:  raw_c = 1'b0;
    endcase
    if (n_en == '0) begin
      raw_c = 1'b0;
    end
  end

  // Stage 1 keeps its last data on idle cycles; only the valid bit drops.
  always_comb begin
    s1_vld_d = bus.in_vld;
    s1_cnt_d = s1_cnt_q;
    s1_raw_d = s1_raw_q;
    if (bus.in_vld) begin
      s1_cnt_d = cnt;
      s1_raw_d = raw_c;
    end
  end

  always_comb begin
    out_vld_d = s1_vld_q;
    count_d   = s1_cnt_q;
    raw_d     = s1_raw_q;
  end

  // Persistence filter: idle cycles leave the run count untouched.
  always_comb begin
    vote_d     = vote_q;
    vote_chg_d = 1'b0;
    hold_cnt_d = hold_cnt_q;
    if (s1_vld_q) begin
      if (s1_raw_q == vote_q) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q == HoldLast) begin
        vote_d     = s1_raw_q;
        vote_chg_d = 1'b1;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HoldCntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_cnt_q   <= '0;
      s1_raw_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      count_q    <= '0;
      raw_q      <= 1'b0;
      vote_q     <= 1'b0;
      vote_chg_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_cnt_q   <= s1_cnt_d;
      s1_raw_q   <= s1_raw_d;
      out_vld_q  <= out_vld_d;
      count_q    <= count_d;
      raw_q      <= raw_d;
      vote_q     <= vote_d;
      vote_chg_q <= vote_chg_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.count    = count_q;
  assign bus.raw      = raw_q;
  assign bus.vote     = vote_q;
  assign bus.vote_chg = vote_chg_q;

endmodule

// File: tb/tb_threshold_voter.sv
// Scoreboard bench: three voter configurations driven in lockstep from one stimulus stream.
module tb_threshold_voter;
  import voter_pkg::*;

  localparam int NumDut = 3;
  localparam int Thresh = 2;

  typedef struct {
    int   cyc;
    int   cnt;
    logic raw;
    logic vote;
    logic chg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld  = 1'b0;
  logic [3:0] bits = '0;
  logic [1:0] md   = '0;
  logic [3:0] en   = 4'hf;
  int         cyc  = 0;

  int n_vec = 0;
  int n_err = 0;

  int   n_of[NumDut]    = '{3, 4, 3};
  int   hold_of[NumDut] = '{1, 1, 3};
  logic m_vote[NumDut];
  int   m_cnt[NumDut];
  exp_t exp_q[NumDut][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  threshold_voter_if #(.N(3)) bus_a ();
  threshold_voter_if #(.N(4)) bus_b ();
  threshold_voter_if #(.N(3)) bus_c ();

  assign bus_a.in_vld  = vld;
  assign bus_a.in_bits = bits[2:0];
  assign bus_a.mode    = md;
  assign bus_b.in_vld  = vld;
  assign bus_b.in_bits = bits;
  assign bus_b.mode    = md;
  assign bus_c.in_vld  = vld;
  assign bus_c.in_bits = bits[2:0];
  assign bus_c.mode    = md;
`ifdef VOTER_CHMASK_EN
  assign bus_a.ch_en   = en[2:0];
  assign bus_b.ch_en   = en;
  assign bus_c.ch_en   = en[2:0];
`endif

  threshold_voter #(.N(3), .THRESH(Thresh), .HOLD(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  threshold_voter #(.N(4), .THRESH(Thresh), .HOLD(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  threshold_voter #(.N(3), .THRESH(Thresh), .HOLD(3)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one sample on DUT d; result lands two cycles later.
  task automatic model_push(input int d, input logic [3:0] b, input logic [1:0] m,
                            input logic [3:0] e);
    int   c  = 0;
    int   ne = 0;
    logic r;
    logic chg = 1'b0;
    logic [3:0] em;
`ifdef VOTER_CHMASK_EN
    em = e;
`else
    em = 4'hf;
`endif
    for (int i = 0; i < n_of[d]; i++) begin
      if (em[i]) ne++;
      if (em[i] && b[i]) c++;
    end
    case (m)
      2'd0:    r = (ne >= 1) && (c == ne);
      2'd1:    r = (2 * c) > ne;
      2'd2:    r = c >= 1;
      default: r = c >= Thresh;
    endcase
    if (ne == 0) r = 1'b0;
    if (r == m_vote[d]) begin
      m_cnt[d] = 0;
    end else if (m_cnt[d] == hold_of[d] - 1) begin
      m_vote[d] = r;
      m_cnt[d]  = 0;
      chg       = 1'b1;
    end else begin
      m_cnt[d]++;
    end
    exp_q[d].push_back('{cyc: cyc + 2, cnt: c, raw: r, vote: m_vote[d], chg: chg});
  endtask

  task automatic apply(input logic v, input logic [3:0] b, input logic [1:0] m,
                       input logic [3:0] e);
    @(posedge clk);
    #1;
    vld  = v;
    bits = b;
    md   = m;
    en   = e;
    if (v) begin
      for (int d = 0; d < NumDut; d++) model_push(d, b, m, e);
    end
  endtask

  task automatic monitor(input int d, input logic ov, input int cnt, input logic raw,
                         input logic vote, input logic chg);
    exp_t e;
    if (!rst_n) return;
    if (ov) begin
      if (exp_q[d].size() == 0) begin
        check_eq($sformatf("spurious_out_vld[%0d]", d), int'(ov), 0);
      end else begin
        e = exp_q[d].pop_front();
        check_eq($sformatf("latency[%0d]", d), cyc, e.cyc);
        check_eq($sformatf("count[%0d]", d), cnt, e.cnt);
        check_eq($sformatf("raw[%0d]", d), int'(raw), int'(e.raw));
        check_eq($sformatf("vote[%0d]", d), int'(vote), int'(e.vote));
        check_eq($sformatf("vote_chg[%0d]", d), int'(chg), int'(e.chg));
      end
    end else begin
      check_eq($sformatf("vote_chg_idle[%0d]", d), int'(chg), 0);
    end
  endtask

  always @(negedge clk) monitor(0, bus_a.out_vld, int'(bus_a.count), bus_a.raw, bus_a.vote,
                                bus_a.vote_chg);
  always @(negedge clk) monitor(1, bus_b.out_vld, int'(bus_b.count), bus_b.raw, bus_b.vote,
                                bus_b.vote_chg);
  always @(negedge clk) monitor(2, bus_c.out_vld, int'(bus_c.count), bus_c.raw, bus_c.vote,
                                bus_c.vote_chg);

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out_vld_a"}, int'(bus_a.out_vld), 0);
    check_eq({tag, "_count_a"}, int'(bus_a.count), 0);
    check_eq({tag, "_raw_a"}, int'(bus_a.raw), 0);
    check_eq({tag, "_vote_a"}, int'(bus_a.vote), 0);
    check_eq({tag, "_vote_chg_a"}, int'(bus_a.vote_chg), 0);
    check_eq({tag, "_out_vld_b"}, int'(bus_b.out_vld), 0);
    check_eq({tag, "_count_b"}, int'(bus_b.count), 0);
    check_eq({tag, "_vote_b"}, int'(bus_b.vote), 0);
    check_eq({tag, "_out_vld_c"}, int'(bus_c.out_vld), 0);
    check_eq({tag, "_count_c"}, int'(bus_c.count), 0);
    check_eq({tag, "_raw_c"}, int'(bus_c.raw), 0);
    check_eq({tag, "_vote_c"}, int'(bus_c.vote), 0);
    check_eq({tag, "_vote_chg_c"}, int'(bus_c.vote_chg), 0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < NumDut; d++) begin
      m_vote[d] = 1'b0;
      m_cnt[d]  = 0;
      exp_q[d].delete();
    end
  endtask

  initial begin
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // ALL: 111 then 110 (N=4 DUT sees 0111, 0110).
    apply(1'b1, 4'b0111, 2'd0, 4'hf);
    apply(1'b1, 4'b0110, 2'd0, 4'hf);
    apply(1'b0, 4'b0000, 2'd0, 4'hf);
    apply(1'b0, 4'b0000, 2'd0, 4'hf);

    // Mode sweep.
    apply(1'b1, 4'b0010, 2'd1, 4'hf);
    apply(1'b1, 4'b0010, 2'd2, 4'hf);
    apply(1'b1, 4'b0010, 2'd3, 4'hf);
    apply(1'b1, 4'b0011, 2'd1, 4'hf);
    apply(1'b1, 4'b0011, 2'd3, 4'hf);
    apply(1'b1, 4'b0011, 2'd0, 4'hf);

    // Even-N majority tie, then a clear majority.
    apply(1'b1, 4'b0011, 2'd1, 4'hf);
    apply(1'b1, 4'b0111, 2'd1, 4'hf);

    // Settle every filter at vote=0 before the HOLD=3 runs.
    repeat (3) apply(1'b1, 4'b0000, 2'd2, 4'hf);
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b0, 4'b0000, 2'd2, 4'hf);
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    repeat (3) apply(1'b1, 4'b0000, 2'd2, 4'hf);
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b1, 4'b0000, 2'd2, 4'hf);
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b1, 4'b0000, 2'd2, 4'hf);

    // Two 001 samples through the filter, then async reset mid-run.
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b0, 4'b0000, 2'd2, 4'hf);
    @(posedge clk);
    #2 rst_n = 1'b0;
    vld = 1'b0;
    model_reset();
    #1 check_all_zero("midrun_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) apply(1'b1, 4'b0001, 2'd2, 4'hf);
    apply(1'b0, 4'b0000, 2'd2, 4'hf);

`ifdef VOTER_CHMASK_EN
    apply(1'b1, 4'b0111, 2'd0, 4'b0011);
    for (int m = 0; m < 4; m++) apply(1'b1, 4'b1111, 2'(m), 4'b0000);
    for (int i = 0; i < 30; i++) begin
      apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
    end
`endif

    for (int i = 0; i < 40; i++) begin
      apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            4'hf);
    end

    apply(1'b0, 4'b0000, 2'd0, 4'hf);
    repeat (4) @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      check_eq($sformatf("drain[%0d]", d), exp_q[d].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
